// File: rtl/ca_word_sampler.sv
// ca_word_sampler: drives an external cellular automaton (seed load + step
// enable) and assembles OUT_WIDTH-bit words from one of its cells. After every
// seed load a fixed number of CA steps is discarded, then bits are collected
// MSB-first and handed out on a valid/ready interface. All outputs registered.
module ca_word_sampler #(
    parameter int                  CA_WIDTH     = 16,
    parameter int                  OUT_WIDTH    = 32,
    parameter int                  TAP          = CA_WIDTH / 2,
    parameter int                  WARMUP       = 8,
    parameter logic [CA_WIDTH-1:0] DEFAULT_SEED = {(CA_WIDTH / 2){2'b01}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_load,
    input  logic [CA_WIDTH-1:0]  seed,
    input  logic [CA_WIDTH-1:0]  ca_state,
    output logic                 ca_load,
    output logic [CA_WIDTH-1:0]  ca_set,
    output logic                 ca_ce,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [15:0]          word_count
);

    // Bit counter must be able to hold OUT_WIDTH itself (value while in HOLD).
    localparam int BW = $clog2(OUT_WIDTH + 1);

    typedef enum logic [1:0] {
        S_SEED,
        S_WARMUP,
        S_COLLECT,
        S_HOLD
    } state_t;

    state_t               state_reg;
    logic                 reseed_reg;
    logic [7:0]           warm_cnt_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic [OUT_WIDTH-1:0] shift_reg;
    logic [OUT_WIDTH-1:0] shift_next;

    // Shift register with the pre-step tap value appended at the LSB, so the
    // earliest sampled bit migrates up to the MSB of the finished word.
    always_comb begin
        shift_next    = shift_reg << 1;
        shift_next[0] = ca_state[TAP];
    end

    // Main sequencer: reset, then reseed requests, then the per-state work.
    // Every output is assigned here so none of them is combinational.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_SEED;
            // Reset itself is followed by one genuine SEED cycle, so the
            // reset-to-first-word timing matches reseed-to-first-word timing.
            reseed_reg   <= 1'b1;
            warm_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            ca_load      <= 1'b1;
            ca_set       <= DEFAULT_SEED;
            ca_ce        <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            word_count   <= '0;
            busy         <= 1'b1;
        end else if (seed_load) begin
            // Reseeding wins over everything, including a pending handshake;
            // any partially assembled or waiting word is abandoned.
            state_reg    <= S_SEED;
            reseed_reg   <= 1'b0;
            warm_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            ca_load      <= 1'b1;
            ca_set       <= (seed == '0) ? DEFAULT_SEED : seed;
            ca_ce        <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b1;
        end else begin
            case (state_reg)
                S_SEED: begin
                    if (reseed_reg) begin
                        // First cycle after reset: keep presenting the seed.
                        reseed_reg <= 1'b0;
                    end else if (WARMUP == 0) begin
                        state_reg   <= S_COLLECT;
                        bit_cnt_reg <= '0;
                        ca_load     <= 1'b0;
                        ca_ce       <= 1'b1;
                    end else begin
                        state_reg    <= S_WARMUP;
                        warm_cnt_reg <= 8'(WARMUP);
                        ca_load      <= 1'b0;
                        ca_ce        <= 1'b1;
                    end
                end
                S_WARMUP: begin
                    // CA keeps stepping; leave after the last discarded step.
                    warm_cnt_reg <= warm_cnt_reg - 8'd1;
                    if (warm_cnt_reg == 8'd1) begin
                        state_reg   <= S_COLLECT;
                        bit_cnt_reg <= '0;
                    end
                end
                S_COLLECT: begin
                    shift_reg   <= shift_next;
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BW'(OUT_WIDTH - 1)) begin
                        state_reg <= S_HOLD;
                        out_data  <= shift_next;
                        out_valid <= 1'b1;
                        ca_ce     <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // CA is frozen here, so the next word continues the
                    // trajectory exactly where this one stopped.
                    if (out_ready) begin
                        state_reg   <= S_COLLECT;
                        bit_cnt_reg <= '0;
                        word_count  <= word_count + 16'd1;
                        out_valid   <= 1'b0;
                        ca_ce       <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_SEED;
                    ca_load   <= 1'b1;
                    ca_ce     <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ca_word_sampler.sv
// Testbench for ca_word_sampler: a ring CA (rule 0x32) environment driven by
// the DUT, a word-level expected model, directed scenarios, then random traffic.
module tb_ca_word_sampler;

    localparam int             CW    = 16;
    localparam int             OW    = 8;
    localparam int             TP    = 8;
    localparam int             WU    = 4;
    localparam logic [CW-1:0]  DSEED = 16'h5555;
    localparam logic [7:0]     RULE  = 8'b00110010;
    localparam int             FIRST = WU + OW + 1;   // edges from seed edge to valid

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          seed_load = 1'b0;
    logic [CW-1:0] seed = '0;
    logic [CW-1:0] ca_state;
    logic          ca_load;
    logic [CW-1:0] ca_set;
    logic          ca_ce;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic [15:0]   word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ca_word_sampler #(
        .CA_WIDTH(CW), .OUT_WIDTH(OW), .TAP(TP), .WARMUP(WU), .DEFAULT_SEED(DSEED)
    ) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .ca_state(ca_state), .ca_load(ca_load), .ca_set(ca_set), .ca_ce(ca_ce),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .word_count(word_count)
    );

    // One step of the ring CA: new cell = RULE[{left, self, right}].
    function automatic logic [CW-1:0] ca_step(input logic [CW-1:0] s);
        logic [CW-1:0] n;
        logic [7:0]    rule;
        rule = RULE;
        n    = '0;
        for (int i = 0; i < CW; i++)
            n[i] = rule[{s[(i + 1) % CW], s[i], s[(i + CW - 1) % CW]}];
        return n;
    endfunction

    // Word k after a seed: tap bits of CA steps WU+OW*k .. WU+OW*k+OW-1, MSB first.
    function automatic logic [OW-1:0] word_at(input logic [CW-1:0] s0, input int k);
        logic [CW-1:0] s;
        logic [OW-1:0] w;
        s = s0;
        w = '0;
        for (int i = 0; i < WU + OW * k; i++) s = ca_step(s);
        for (int j = 0; j < OW; j++) begin
            w = {w[OW-2:0], s[TP]};
            s = ca_step(s);
        end
        return w;
    endfunction

    // CA environment driven by the DUT's load/step controls.
    logic [CW-1:0] ca_reg = '0;
    assign ca_state = ca_reg;
    always @(posedge clk) begin
        if (ca_load)    ca_reg <= ca_set;
        else if (ca_ce) ca_reg <= ca_step(ca_reg);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected-behaviour model (updated on each edge) and per-cycle comparison.
    bit            m_live = 1'b0;
    bit            m_valid = 1'b0;
    int            m_cnt = 0;          // edges remaining until out_valid rises
    int            m_idx = 0;          // word index since the last seed
    logic [15:0]   m_count = '0;
    logic [CW-1:0] m_seed = '0;
    logic [OW-1:0] m_word = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_live  = 1'b1;
                m_valid = 1'b0;
                m_cnt   = FIRST + 1;
                m_count = '0;
                m_seed  = DSEED;
                m_idx   = 0;
            end else if (m_live) begin
                if (seed_load) begin
                    m_valid = 1'b0;
                    m_cnt   = FIRST;
                    m_seed  = (seed == '0) ? DSEED : seed;
                    m_idx   = 0;
                end else if (m_valid) begin
                    if (out_ready) begin
                        m_count = m_count + 16'd1;
                        $display("word %0d accepted data %h", m_count, m_word);
                        m_valid = 1'b0;
                        m_cnt   = OW;
                        m_idx++;
                    end
                end else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_valid = 1'b1;
                        m_word  = word_at(m_seed, m_idx);
                    end
                end
            end
            @(negedge clk);
            if (m_live) begin
                chk("out_valid", 64'(out_valid), 64'(m_valid));
                chk("busy", 64'(busy), 64'(!m_valid));
                chk("ca_load", 64'(ca_load), 64'(!m_valid && m_cnt >= FIRST));
                chk("ca_ce", 64'(ca_ce), 64'(!m_valid && m_cnt < FIRST));
                chk("ca_set", 64'(ca_set), 64'(m_seed));
                chk("word_count", 64'(word_count), 64'(m_count));
                if (m_valid) chk("out_data", 64'(out_data), 64'(m_word));
                if (m_cnt == FIRST + 1) chk("out_data_reset", 64'(out_data), 64'd0);
            end
        end
    end

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_seed(input logic [CW-1:0] s);
        seed_load = 1'b1;
        seed      = s;
        next_edge();
        seed_load = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            next_edge();
            n++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: out_valid low after %0d edges, expected high", budget);
        end
    endtask

    int n;
    logic [15:0] saved_count;

    initial begin
        // Pin the model to hand-computed values.
        chk("model_step_5555", 64'(ca_step(16'h5555)), 64'h0000_AAAA);
        chk("model_step_8001", 64'(ca_step(16'h8001)), 64'h0000_4002);
        chk("model_step_4002", 64'(ca_step(16'h4002)), 64'h0000_A005);
        chk("model_word_5555", 64'(word_at(16'h5555, 0)), 64'h0000_00AA);

        // Reset release with out_ready low.
        repeat (3) next_edge();
        rst = 1'b0;
        next_edge();                                   // edge 0
        chk("rel_ca_load_c0", 64'(ca_load), 64'd1);
        chk("rel_ca_ce_c0", 64'(ca_ce), 64'd0);
        next_edge();                                   // edge 1
        chk("rel_ca_load_c1", 64'(ca_load), 64'd0);
        chk("rel_ca_ce_c1", 64'(ca_ce), 64'd1);
        wait_valid(40, n);
        chk("rel_first_valid_edge", 64'(n + 1), 64'(FIRST));
        chk("rel_first_word", 64'(out_data), 64'h0000_00AA);
        repeat (20) next_edge();
        chk("rel_idle_stable", 64'(out_data), 64'h0000_00AA);

        // Zero seed falls back to the default seed.
        pulse_seed(16'h0000);
        chk("seed0_ca_set", 64'(ca_set), 64'h0000_5555);
        wait_valid(40, n);
        chk("seed0_latency", 64'(n), 64'(FIRST));

        // Nonzero seed, then back-to-back words with out_ready held high.
        out_ready = 1'b1;
        pulse_seed(16'h8001);
        chk("seed8001_ca_set", 64'(ca_set), 64'h0000_8001);
        wait_valid(40, n);
        chk("seed8001_latency", 64'(n), 64'(FIRST));
        for (int k = 1; k <= 3; k++) begin
            next_edge();
            chk("stream_word_count", 64'(word_count), 64'(k));
            chk("stream_valid_drop", 64'(out_valid), 64'd0);
            wait_valid(40, n);
            chk("stream_period", 64'(n + 1), 64'(OW + 1));
        end
        out_ready = 1'b0;

        // Reseed after 3 collected bits: partial word is dropped.
        pulse_seed(16'h1234);
        repeat (8) next_edge();
        pulse_seed(16'hBEEF);
        wait_valid(40, n);
        chk("partial_reseed_latency", 64'(n), 64'(FIRST));

        // Reseed on the same edge as a HOLD handshake.
        saved_count = word_count;
        out_ready   = 1'b1;
        pulse_seed(16'h0F0F);
        out_ready   = 1'b0;
        chk("clash_word_count", 64'(word_count), 64'(saved_count));
        chk("clash_valid", 64'(out_valid), 64'd0);
        wait_valid(40, n);

        // One-cycle reset in HOLD.
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        chk("hold_rst_ca_load", 64'(ca_load), 64'd1);
        chk("hold_rst_ca_set", 64'(ca_set), 64'h0000_5555);
        chk("hold_rst_ca_ce", 64'(ca_ce), 64'd0);
        chk("hold_rst_valid", 64'(out_valid), 64'd0);
        chk("hold_rst_data", 64'(out_data), 64'd0);
        chk("hold_rst_count", 64'(word_count), 64'd0);
        chk("hold_rst_busy", 64'(busy), 64'd1);
        wait_valid(40, n);
        chk("hold_rst_latency", 64'(n), 64'(FIRST + 1));
        chk("hold_rst_word", 64'(out_data), 64'h0000_00AA);

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            seed_load = ($urandom_range(0, 39) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rst       = ($urandom_range(0, 299) == 0);
            next_edge();
        end
        rst       = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b0;
        next_edge();
        next_edge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ca_word_sampler.md
CA_WORD_SAMPLER -- requirements
Module: ca_word_sampler

Interface
REQ-001 The block SHALL have parameter CA_WIDTH, default 16: width of the cellular-automaton state it drives and samples.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 32: bits per output word (range 1..64).
REQ-003 The block SHALL have parameter TAP, default CA_WIDTH/2: index of the sampled CA cell (0..CA_WIDTH-1).
REQ-004 The block SHALL have parameter WARMUP, default 8: CA steps discarded after every seed load (range 0..255).
REQ-005 The block SHALL have parameter DEFAULT_SEED, default {(CA_WIDTH/2){2'b01}}: seed used after reset and in place of an all-zero seed.
REQ-006 The block SHALL have the following ports: clk input 1 (sole clock, rising edge); rst input 1 (synchronous, active-high reset).
REQ-007 The block SHALL have the following ports: seed_load input 1 (request to reseed); seed input CA_WIDTH (new seed value).
REQ-008 The block SHALL have the following ports: ca_state input CA_WIDTH (current CA state); ca_load output 1 (registered, drives CA seed-load/rst); ca_set output CA_WIDTH (registered seed to CA); ca_ce output 1 (registered CA step enable).
REQ-009 The block SHALL have the following ports: out_data output OUT_WIDTH; out_valid output 1; out_ready input 1; busy output 1 (high unless in HOLD); word_count output 16 (accepted words).

Function
REQ-010 The FSM SHALL have exactly the states SEED, WARMUP, COLLECT and HOLD.
REQ-011 SEED SHALL last exactly one cycle with ca_load=1 and ca_ce=0, then go to WARMUP, or straight to COLLECT when WARMUP=0.
REQ-012 WARMUP SHALL hold ca_ce=1 for exactly WARMUP cycles, counted by an 8-bit down-counter, then go to COLLECT.
REQ-013 COLLECT SHALL hold ca_ce=1 for exactly OUT_WIDTH cycles; each cycle it SHALL shift ca_state[TAP] (the pre-step value) into the LSB of the shift register, so the first sampled bit ends up as the MSB of out_data.
REQ-014 After the OUT_WIDTH-th bit, the block SHALL load out_data and enter HOLD with out_valid=1 and ca_ce=0.
REQ-015 In HOLD, out_data and out_valid SHALL stay stable until out_valid and out_ready are both high on the same edge.
REQ-016 On that handshake edge the block SHALL increment word_count (16-bit, wrapping FFFF->0000), clear out_valid, clear the bit counter and enter COLLECT; no new warmup SHALL occur.
REQ-017 seed_load=1 SHALL be accepted in any state: the next state is SEED, ca_set = seed (or DEFAULT_SEED if seed==0), out_valid is cleared, and partial shift-register contents are discarded.
REQ-018 When seed_load coincides with a HOLD handshake, seed_load SHALL win: word_count is not incremented and the word is dropped.
REQ-019 out_ready SHALL be ignored outside HOLD.
REQ-020 busy SHALL equal 1 in SEED, WARMUP and COLLECT, and 0 in HOLD.
REQ-021 Latency: with cycle 0 being the first edge after rst falls, out_valid SHALL first be high after edge WARMUP+OUT_WIDTH+1; with out_ready held at 1, successive words SHALL appear every OUT_WIDTH+1 cycles.

Reset
REQ-022 While rst=1 at a clock edge, state SHALL be SEED, ca_load=1, ca_set=DEFAULT_SEED, ca_ce=0, out_valid=0, out_data=0, word_count=0, busy=1, and all counters and the shift register SHALL be 0.
REQ-023 rst SHALL override seed_load and out_ready, including mid-COLLECT and in HOLD.
REQ-024 All outputs SHALL be registered; no output SHALL depend combinationally on any input.

Verification
Common setup: CA_WIDTH=16, OUT_WIDTH=8, TAP=8, WARMUP=4, DEFAULT_SEED=16'h5555; the bench includes a reference rule-8'b00110010 ring CA model driven by ca_load/ca_set/ca_ce.
REQ-025 Scenario: release rst with out_ready=0 -> ca_load=1 in cycle 0 only; ca_ce=1 in cycles 1-12; out_valid rises after edge 13; out_data equals the model's tap bits from steps 4-11, MSB first, and stays stable for 20 idle cycles.
REQ-026 Scenario: hold out_ready=1 -> out_valid is high for one cycle every 9 cycles; word_count reads 1, 2, 3 after each handshake, and every word matches the model.
REQ-027 Scenario: seed_load with seed=16'h0000 -> ca_set=16'h5555 and a full SEED/WARMUP/COLLECT sequence follows; seed=16'h8001 -> ca_set=16'h8001.
REQ-028 Scenario: seed_load after 3 COLLECT bits -> the partial word is never output; out_valid rises 13 edges after the seed_load edge.
REQ-029 Scenario: seed_load and out_ready asserted on the same HOLD edge -> word_count is unchanged and out_valid=0 on the next cycle.
REQ-030 Scenario: rst pulsed for one cycle during HOLD -> all REQ-022 values hold on the next cycle and the first-word timing of REQ-025 repeats.
